// File: rtl/mmc_pkg.sv
// Types and helpers shared by the MMC arm control blocks (sorter, gate scheduler).
package mmc_pkg;

  localparam int N_SM_DEF = 12;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_BLANK, ST_DWELL} state_e;

  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 64; i++) c += 32'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/mmc_interval_timer.sv
// Loadable down-counter; done_o is high on the last cycle of the loaded interval.
module mmc_interval_timer #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt_q <= RST_VAL;
    else if (load_i)         cnt_q <= val_i;
    else if (cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
  end

  assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/mmc_gate_scheduler.sv
// Applies sorter insertion masks to half-bridge gates with per-submodule dead-time and dwell.
module mmc_gate_scheduler
  import mmc_pkg::*;
#(
  parameter int N_SM      = N_SM_DEF,
  parameter int DEAD_CYC  = 20,
  parameter int DWELL_CYC = 100,
  parameter int CNT_W     = 16,
  localparam int NW       = $clog2(N_SM + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mask_valid,
  input  logic [N_SM-1:0]  mask,
  input  logic [NW-1:0]    n_req,
  output logic             mask_ready,
  output logic [N_SM-1:0]  gate_up,
  output logic [N_SM-1:0]  gate_lo,
  output logic [N_SM-1:0]  inserted,
  output logic             busy,
  output logic [CNT_W-1:0] sw_events,
  output logic             pop_err
);

  localparam int TMAX = (DEAD_CYC > DWELL_CYC) ? DEAD_CYC : DWELL_CYC;
  localparam int TW   = (TMAX < 1) ? 1 : $clog2(TMAX + 1);

  state_e            state_q;
  logic [N_SM-1:0]   gate_up_q, gate_lo_q, ins_q, pend_q;
  logic [CNT_W-1:0]  sw_q;
  logic              err_q, rdy_q, busy_q, init_lo_q;

  logic              accept, tmr_done, tmr_load;
  logic [TW-1:0]     tmr_val;
  logic [N_SM-1:0]   chg;
  logic [NW-1:0]     chg_n, mask_n;
  logic [CNT_W:0]    sw_sum;

  assign accept = mask_valid & rdy_q;
  assign chg    = mask ^ ins_q;
  assign chg_n  = NW'(popcount(64'(chg)));
  assign mask_n = NW'(popcount(64'(mask)));
  assign sw_sum = {1'b0, sw_q} + (CNT_W + 1)'(chg_n);

  // One timer serves INIT and BLANK (dead-time) and DWELL; reset preloads the INIT interval.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TW'(DEAD_CYC);
    if (state_q == ST_IDLE && accept && chg != '0) begin
      tmr_load = 1'b1;
    end else if (state_q == ST_BLANK && tmr_done) begin
      tmr_load = 1'b1;
      tmr_val  = TW'(DWELL_CYC);
    end
  end

  mmc_interval_timer #(.W(TW), .RST_VAL(TW'(DEAD_CYC))) u_tmr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (tmr_load),
    .val_i  (tmr_val),
    .done_o (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      gate_up_q <= '0;
      gate_lo_q <= '0;
      ins_q     <= '0;
      pend_q    <= '0;
      sw_q      <= '0;
      err_q     <= 1'b0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b1;
      init_lo_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          // Bypass all submodules once the off interval ends, enter IDLE a cycle later.
          if (init_lo_q) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else if (tmr_done) begin
            gate_lo_q <= '1;
            init_lo_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (accept) begin
            pend_q <= mask;
            if (mask_n != n_req) err_q <= 1'b1;
            if (chg != '0) begin
              gate_up_q <= gate_up_q & ~chg;
              gate_lo_q <= gate_lo_q & ~chg;
              sw_q      <= sw_sum[CNT_W] ? '1 : sw_sum[CNT_W-1:0];
              state_q   <= ST_BLANK;
              rdy_q     <= 1'b0;
              busy_q    <= 1'b1;
            end
          end
        end
        ST_BLANK: begin
          if (tmr_done) begin
            gate_up_q <= pend_q;
            gate_lo_q <= ~pend_q;
            ins_q     <= pend_q;
            if (DWELL_CYC == 0) begin
              state_q <= ST_IDLE;
              rdy_q   <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_DWELL;
            end
          end
        end
        ST_DWELL: begin
          if (tmr_done) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign mask_ready = rdy_q;
  assign busy       = busy_q;
  assign gate_up    = gate_up_q;
  assign gate_lo    = gate_lo_q;
  assign inserted   = ins_q;
  assign sw_events  = sw_q;
  assign pop_err    = err_q;

endmodule

// File: tb/tb_mmc_gate_scheduler.sv
// Randomized and directed check of mmc_gate_scheduler against a transaction-level reference model.
module tb_mmc_gate_scheduler;
  localparam int N     = 12;
  localparam int DEAD  = 20;
  localparam int DWELL = 100;
  localparam int CW    = 6;
  localparam int NW    = 4;
  localparam int SWMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mask_valid = 1'b0;
  logic [N-1:0]  mask = '0;
  logic [NW-1:0] n_req = '0;
  logic          mask_ready, busy, pop_err;
  logic [N-1:0]  gate_up, gate_lo, inserted;
  logic [CW-1:0] sw_events;

  int n_chk = 0;
  int n_bad = 0;

  logic [N-1:0] m_ins;
  int           m_sw;
  bit           m_err;

  mmc_gate_scheduler #(.N_SM(N), .DEAD_CYC(DEAD), .DWELL_CYC(DWELL), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .mask_valid(mask_valid), .mask(mask), .n_req(n_req),
    .mask_ready(mask_ready), .gate_up(gate_up), .gate_lo(gate_lo), .inserted(inserted),
    .busy(busy), .sw_events(sw_events), .pop_err(pop_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  always @(negedge clk) chk("excl", 32'(gate_up & gate_lo), 32'(0));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state();
    chk("rst_gates", {8'h0, gate_up, gate_lo}, 32'(0));
    chk("rst_ins",   32'(inserted), 32'(0));
    chk("rst_sw",    32'(sw_events), 32'(0));
    chk("rst_err",   32'(pop_err), 32'(0));
    chk("rst_rdy_busy", {30'h0, mask_ready, busy}, 32'h1);
  endtask

  // Release reset just after an edge, then walk the INIT sequence.
  task automatic do_init();
    rst_n = 1'b1;
    m_ins = '0; m_sw = 0; m_err = 1'b0;
    for (int k = 1; k < DEAD; k++) begin
      tick();
      chk("init_off", {8'h0, gate_up, gate_lo}, 32'(0));
    end
    tick();
    chk("init_lo", {8'h0, gate_up, gate_lo}, {8'h0, 12'h000, 12'hFFF});
    chk("init_rdy0", 32'(mask_ready), 32'(0));
    tick();
    chk("init_rdy1", {30'h0, mask_ready, busy}, 32'h2);
  endtask

  task automatic do_tx(input logic [N-1:0] m, input int n, input bit hold,
                       input logic [N-1:0] hm, input int hn);
    logic [N-1:0] chg;
    int           w;
    chk("tx_rdy_pre", 32'(mask_ready), 32'(1));
    mask = m; n_req = NW'(n); mask_valid = 1'b1;
    tick();
    mask_valid = 1'b0;
    chg = m ^ m_ins;
    if ($countones(m) != n) m_err = 1'b1;
    if (chg != '0) m_sw = (m_sw + $countones(chg) > SWMAX) ? SWMAX : m_sw + $countones(chg);
    chk("tx_err", 32'(pop_err), 32'(m_err));
    chk("tx_sw",  32'(sw_events), 32'(m_sw));
    if (chg == '0) begin
      chk("same_rdy", {30'h0, mask_ready, busy}, 32'h2);
      chk("same_gates", {8'h0, gate_up, gate_lo}, {8'h0, m_ins, ~m_ins});
      return;
    end
    for (int i = 0; i < DEAD; i++) begin
      chk("blank", {7'h0, mask_ready, gate_up, gate_lo}, {7'h0, 1'b0, m_ins & ~chg, ~m_ins & ~chg});
      tick();
    end
    chk("applied", {8'h0, gate_up, gate_lo}, {8'h0, m, ~m});
    chk("applied_ins", 32'(inserted), 32'(m));
    m_ins = m;
    if (hold) begin
      mask = hm; n_req = NW'(hn); mask_valid = 1'b1;
    end
    w = 0;
    while (!mask_ready && w < DWELL + 50) begin
      tick();
      w++;
    end
    chk("dwell_len", 32'(w), 32'(DWELL));
    chk("dwell_ins", 32'(inserted), 32'(m_ins));
  endtask

  initial begin
    logic [N-1:0] rm;
    int rn;
    tick(); tick();
    chk_reset_state();
    do_init();

    do_tx(12'h005, 2, 1'b0, '0, 0);
    chk("t2_sw", 32'(sw_events), 32'(2));
    do_tx(12'h006, 2, 1'b0, '0, 0);
    chk("t3_sw", 32'(sw_events), 32'(4));
    do_tx(12'h006, 3, 1'b0, '0, 0);
    chk("t4_err", 32'(pop_err), 32'(1));
    do_tx(12'h0A0, 2, 1'b1, 12'hFFF, 12);
    do_tx(12'hFFF, 12, 1'b0, '0, 0);

    for (int t = 0; t < 30; t++) begin
      rm = ($urandom_range(0, 3) == 0) ? m_ins : N'($urandom);
      rn = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N)) : $countones(rm);
      do_tx(rm, rn, 1'b0, '0, 0);
    end
    chk("sat_sw", 32'(sw_events), 32'(m_sw));

    // Reset in the middle of a blanking interval.
    rm = ~m_ins;
    chk("t6_rdy", 32'(mask_ready), 32'(1));
    mask = rm; n_req = NW'($countones(rm)); mask_valid = 1'b1;
    tick();
    mask_valid = 1'b0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1 chk_reset_state();
    tick();
    do_init();
    do_tx(12'h00F, 4, 1'b0, '0, 0);

    $display("%0d/%0d checks passed", n_chk - n_bad, n_chk);
    $finish;
  end

endmodule
